adc_sample_sequencer: RTL and testbench

ADC_SAMPLE_SEQUENCER -- requirements
Module: adc_sample_sequencer

---
 rtl/adc_sample_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_sequencer.sv
// ADC sample sequencer: scans the enabled amux channels, triggers one conversion
// per channel and queues {channel, measurement} samples in a fall-through FIFO.
module adc_sample_sequencer #(
    parameter int CH_WIDTH       = 2,
    parameter int MEAS_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           enable_i,
    input  logic [2**CH_WIDTH-1:0]         ch_mask_i,
    input  logic                           status_clr_i,
    output logic                           busy_o,
    output logic [CH_WIDTH-1:0]            amux_sel_o,
    output logic                           adc_trigger_o,
    input  logic                           adc_done_i,
    input  logic [MEAS_WIDTH-1:0]          adc_data_i,
    input  logic                           rd_en_i,
    output logic [CH_WIDTH+MEAS_WIDTH-1:0] rd_data_o,
    output logic                           fifo_empty_o,
    output logic                           fifo_full_o,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count_o,
    output logic                           overflow_o,
    output logic                           timeout_err_o
);

    localparam int NCH = 2**CH_WIDTH;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int EW  = CH_WIDTH + MEAS_WIDTH;
    localparam int SW  = $clog2(SETTLE_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT     = CW'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_TRIGGER = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_STORE   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [CH_WIDTH-1:0]   sel_q, sel_d;
    logic [CH_WIDTH-1:0]   next_idx_q, next_idx_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [MEAS_WIDTH-1:0] cap_q, cap_d;
    logic                  overflow_q, overflow_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [EW-1:0]         mem_q [FIFO_DEPTH];

    logic                  scan_ok;
    logic                  advance;
    logic                  store_req;
    logic                  timeout_set;
    logic                  do_read;
    logic                  do_write;
    logic                  overflow_set;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CH_WIDTH-1:0]   sel_plus1;

    // Lowest set mask bit at or above start, searching circularly.
    function automatic logic [CH_WIDTH-1:0] first_set_from(
        input logic [NCH-1:0]      mask,
        input logic [CH_WIDTH-1:0] start
    );
        logic [CH_WIDTH-1:0] idx;
        logic                found;
        first_set_from = start;
        found          = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = start + CH_WIDTH'(i);
            if (!found && mask[idx]) begin
                first_set_from = idx;
                found          = 1'b1;
            end
        end
    endfunction

    assign scan_ok   = enable_i && (ch_mask_i != '0);
    assign sel_plus1 = sel_q + CH_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        next_idx_d  = next_idx_q;
        settle_d    = settle_q;
        tmo_d       = tmo_q;
        cap_d       = cap_q;
        advance     = 1'b0;
        store_req   = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scan_ok) begin
                    state_d  = ST_SELECT;
                    sel_d    = first_set_from(ch_mask_i, next_idx_q);
                    settle_d = '0;
                end
            end
            ST_SELECT: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_TRIGGER;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_TRIGGER: begin
                state_d = ST_WAIT;
                tmo_d   = '0;
            end
            ST_WAIT: begin
                if (adc_done_i) begin
                    cap_d   = adc_data_i;
                    state_d = ST_STORE;
                end else if (tmo_q == TIMEOUT_LAST) begin
                    timeout_set = 1'b1;
                    advance     = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_STORE: begin
                store_req = 1'b1;
                advance   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Store and timeout share one exit: the only other points where enable and mask are sampled.
        if (advance) begin
            next_idx_d = sel_plus1;
            if (scan_ok) begin
                state_d  = ST_SELECT;
                sel_d    = first_set_from(ch_mask_i, sel_plus1);
                settle_d = '0;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == FULL_CNT);
    assign do_read      = rd_en_i && !fifo_empty;
    assign do_write     = store_req && (!fifo_full || do_read);
    assign overflow_set = store_req && fifo_full && !do_read;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_read)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_write, do_read})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A set event in the same cycle as a clear leaves the flag set.
    always_comb begin
        overflow_d    = overflow_q;
        timeout_err_d = timeout_err_q;
        if (status_clr_i) begin
            overflow_d    = 1'b0;
            timeout_err_d = 1'b0;
        end
        if (overflow_set) overflow_d    = 1'b1;
        if (timeout_set)  timeout_err_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            next_idx_q    <= '0;
            settle_q      <= '0;
            tmo_q         <= '0;
            cap_q         <= '0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            next_idx_q    <= next_idx_d;
            settle_q      <= settle_d;
            tmo_q         <= tmo_d;
            cap_q         <= cap_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write && !reset_i) mem_q[wr_ptr_q] <= {sel_q, cap_q};
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign amux_sel_o    = sel_q;
    assign adc_trigger_o = (state_q == ST_TRIGGER);
    assign rd_data_o     = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_empty_o  = fifo_empty;
    assign fifo_full_o   = fifo_full;
    assign fifo_count_o  = count_q;
    assign overflow_o    = overflow_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: directed scenarios plus randomized scans,
// checked against a transaction-level model of the channel schedule and sample queue.
module tb_adc_sample_sequencer;

    localparam int CHW     = 2;
    localparam int MW      = 16;
    localparam int DEPTH   = 8;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 255;
    localparam int NCH     = 4;
    localparam int EW      = CHW + MW;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           enable_i;
    logic [NCH-1:0] ch_mask_i;
    logic           status_clr_i;
    logic           busy_o;
    logic [CHW-1:0] amux_sel_o;
    logic           adc_trigger_o;
    logic           adc_done_i;
    logic [MW-1:0]  adc_data_i;
    logic           rd_en_i;
    logic [EW-1:0]  rd_data_o;
    logic           fifo_empty_o;
    logic           fifo_full_o;
    logic [3:0]     fifo_count_o;
    logic           overflow_o;
    logic           timeout_err_o;

    int checks = 0;
    int fails  = 0;

    logic [EW-1:0] modelQ[$];
    bit            modelOvf;
    bit            modelTmo;
    int            modelNext;

    adc_sample_sequencer #(
        .CH_WIDTH(CHW), .MEAS_WIDTH(MW), .FIFO_DEPTH(DEPTH),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .ch_mask_i(ch_mask_i),
        .status_clr_i(status_clr_i), .busy_o(busy_o), .amux_sel_o(amux_sel_o),
        .adc_trigger_o(adc_trigger_o), .adc_done_i(adc_done_i), .adc_data_i(adc_data_i),
        .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .fifo_empty_o(fifo_empty_o),
        .fifo_full_o(fifo_full_o), .fifo_count_o(fifo_count_o), .overflow_o(overflow_o),
        .timeout_err_o(timeout_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int nextSetFrom(input logic [NCH-1:0] mask, input int start);
        for (int off = 0; off < NCH; off++) begin
            if (mask[(start + off) % NCH]) return (start + off) % NCH;
        end
        return 0;
    endfunction

    task automatic checkFifoState();
        logic [EW-1:0] head;
        head = (modelQ.size() > 0) ? modelQ[0] : '0;
        checkOutput("fifo_count", 64'(fifo_count_o), 64'(modelQ.size()));
        checkOutput("fifo_empty", 64'(fifo_empty_o), 64'(modelQ.size() == 0));
        checkOutput("fifo_full", 64'(fifo_full_o), 64'(modelQ.size() == DEPTH));
        checkOutput("rd_data", 64'(rd_data_o), 64'(head));
        checkOutput("overflow", 64'(overflow_o), 64'(modelOvf));
        checkOutput("timeout_err", 64'(timeout_err_o), 64'(modelTmo));
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelOvf  = 1'b0;
        modelTmo  = 1'b0;
        modelNext = 0;
    endtask

    // Called in IDLE; the next edge starts SELECT.
    task automatic startScan(input logic [NCH-1:0] mask);
        checkOutput("idle_busy", 64'(busy_o), 64'(0));
        ch_mask_i = mask;
        enable_i  = 1'b1;
        step();
    endtask

    task automatic drainFifo(input int n);
        for (int i = 0; i < n; i++) begin
            checkFifoState();
            rd_en_i = 1'b1;
            step();
            rd_en_i = 1'b0;
            if (modelQ.size() > 0) void'(modelQ.pop_front());
        end
        checkFifoState();
    endtask

    task automatic clearStatus();
        status_clr_i = 1'b1;
        step();
        status_clr_i = 1'b0;
        modelOvf = 1'b0;
        modelTmo = 1'b0;
        checkFifoState();
    endtask

    // One conversion from the first SELECT cycle through its exit. doneAt is the WAIT cycle
    // (1 = first after the trigger) carrying adc_done; 0 means the ADC never answers.
    task automatic runConversion(input int doneAt, input bit chData, input bit rdAtStore,
                                 input bit clrAtStore, input bit dropEnable, input bit abortInWait);
        int            ch;
        logic [MW-1:0] data;
        bit            stored;
        bit            doRead;
        bit            setOvf;
        ch     = nextSetFrom(ch_mask_i, modelNext);
        data   = chData ? MW'(16'h0100 + ch) : MW'($urandom);
        stored = 1'b0;
        for (int s = 0; s < SETTLE; s++) begin
            checkOutput("settle_sel", 64'(amux_sel_o), 64'(ch));
            checkOutput("settle_trigger", 64'(adc_trigger_o), 64'(0));
            checkOutput("settle_busy", 64'(busy_o), 64'(1));
            adc_done_i = 1'($urandom_range(0, 1));
            adc_data_i = MW'($urandom);
            step();
        end
        checkOutput("trigger_pulse", 64'(adc_trigger_o), 64'(1));
        checkOutput("trigger_sel", 64'(amux_sel_o), 64'(ch));
        adc_done_i = 1'($urandom_range(0, 1));
        step();
        adc_done_i = 1'b0;
        if (dropEnable) enable_i = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            checkOutput("wait_trigger", 64'(adc_trigger_o), 64'(0));
            checkOutput("wait_busy", 64'(busy_o), 64'(1));
            if (abortInWait && k == 2) begin
                reset_i  = 1'b1;
                enable_i = 1'b0;
                step();
                reset_i  = 1'b0;
                modelReset();
                return;
            end
            if (k == doneAt) begin
                adc_done_i = 1'b1;
                adc_data_i = data;
                step();
                adc_done_i = 1'b0;
                adc_data_i = MW'($urandom);
                stored     = 1'b1;
                break;
            end
            step();
        end
        if (stored) begin
            checkOutput("store_busy", 64'(busy_o), 64'(1));
            checkOutput("store_trigger", 64'(adc_trigger_o), 64'(0));
            rd_en_i      = rdAtStore;
            status_clr_i = clrAtStore;
            doRead = rdAtStore && (modelQ.size() > 0);
            setOvf = (modelQ.size() == DEPTH) && !doRead;
            if (!setOvf) begin
                if (doRead) void'(modelQ.pop_front());
                modelQ.push_back({CHW'(ch), data});
            end
            if (clrAtStore) begin
                modelOvf = setOvf;
                modelTmo = 1'b0;
            end else begin
                modelOvf = modelOvf | setOvf;
            end
            step();
            rd_en_i      = 1'b0;
            status_clr_i = 1'b0;
        end else begin
            modelTmo = 1'b1;
        end
        modelNext = (ch + 1) % NCH;
        checkFifoState();
        checkOutput("exit_busy", 64'(busy_o), 64'(enable_i && (ch_mask_i != '0)));
    endtask

    task automatic applyStimulus(input int nConv);
        int done;
        int dAt;
        bit last;
        done = 0;
        while (done < nConv) begin
            if (modelQ.size() > 0 && $urandom_range(0, 1) == 1) drainFifo($urandom_range(1, modelQ.size()));
            if ($urandom_range(0, 3) == 0) clearStatus();
            startScan(NCH'($urandom_range(1, 15)));
            forever begin
                dAt  = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, 8);
                last = ($urandom_range(0, 4) == 0) || (done == nConv - 1);
                runConversion(dAt, 1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), last, 1'b0);
                done++;
                if (last) break;
            end
        end
    endtask

    initial begin
        reset_i = 1'b1; enable_i = 1'b1; ch_mask_i = 4'hF; status_clr_i = 1'b1;
        adc_done_i = 1'b1; adc_data_i = 16'hBEEF; rd_en_i = 1'b1;
        modelReset();
        step();
        step();
        checkOutput("reset_sel", 64'(amux_sel_o), 64'(0));
        checkOutput("reset_trigger", 64'(adc_trigger_o), 64'(0));
        checkOutput("reset_busy", 64'(busy_o), 64'(0));
        checkFifoState();
        enable_i = 1'b0; status_clr_i = 1'b0; adc_done_i = 1'b0; rd_en_i = 1'b0;
        reset_i = 1'b0;
        step();

        // Idle holds when disabled or with an empty mask.
        enable_i = 1'b1; ch_mask_i = '0;
        step(); step();
        checkOutput("idle_mask0_busy", 64'(busy_o), 64'(0));
        enable_i = 1'b0; ch_mask_i = 4'b1010;
        step(); step();
        checkOutput("idle_disabled_busy", 64'(busy_o), 64'(0));

        // Scan 4'b1010 with a 3-cycle ADC: channels 1, 3, 1.
        startScan(4'b1010);
        runConversion(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runConversion(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runConversion(3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("scan_head", 64'(rd_data_o), 64'({2'd1, 16'h0101}));
        checkOutput("scan_count", 64'(fifo_count_o), 64'(3));
        drainFifo(3);

        // Nine conversions without reads; clear on the dropping store loses to the set.
        startScan(4'b0001);
        for (int i = 0; i < 9; i++) begin
            runConversion($urandom_range(1, 5), 1'b0, 1'b0, (i == 8), (i == 8), 1'b0);
        end
        checkOutput("ovf_full", 64'(fifo_full_o), 64'(1));
        checkOutput("ovf_count", 64'(fifo_count_o), 64'(8));
        checkOutput("ovf_flag", 64'(overflow_o), 64'(1));
        clearStatus();
        checkOutput("ovf_cleared", 64'(overflow_o), 64'(0));

        // Full FIFO with a read in the store cycle: write accepted, no overflow.
        startScan(4'b0001);
        runConversion(2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("full_rw_count", 64'(fifo_count_o), 64'(8));
        checkOutput("full_rw_ovf", 64'(overflow_o), 64'(0));
        drainFifo(8);
        drainFifo(1);

        // ADC never answers on the first channel; the scan moves on.
        startScan(4'b0101);
        runConversion(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("tmo_flag", 64'(timeout_err_o), 64'(1));
        checkOutput("tmo_no_write", 64'(fifo_count_o), 64'(0));
        runConversion(4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        clearStatus();

        applyStimulus(40);
        drainFifo(modelQ.size());
        clearStatus();

        // Reset during WAIT with three entries held; a late adc_done is ignored.
        startScan(NCH'($urandom_range(1, 15)));
        for (int i = 0; i < 3; i++) runConversion(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_abort_count", 64'(fifo_count_o), 64'(3));
        runConversion(5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("abort_busy", 64'(busy_o), 64'(0));
        checkOutput("abort_sel", 64'(amux_sel_o), 64'(0));
        checkFifoState();
        adc_done_i = 1'b1;
        adc_data_i = 16'h1234;
        step();
        adc_done_i = 1'b0;
        step();
        checkOutput("late_done_busy", 64'(busy_o), 64'(0));
        checkFifoState();

        // Restart after reset begins from channel 0 upward.
        startScan(4'b1111);
        checkOutput("restart_sel", 64'(amux_sel_o), 64'(0));
        runConversion(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
